// File: rtl/fp_addsub_unit.sv
`timescale 1ns/1ps
// fp_addsub_unit: multi-cycle binary32 FADD.S/FSUB.S unit feeding the float register file write port.
// Optional macro FPU_FLAGS_EN adds the registered fflags output {NV,DZ,OF,UF,NX}.
module fp_addsub_unit #(
    parameter int unsigned LATENCY_STAGES = 4,
    parameter logic [31:0] CANON_NAN      = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [5:0]  in_rd_addr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        kill,
    output logic        busy,
    output logic        float_wb_en,
    output logic [5:0]  float_wb_addr,
`ifdef FPU_FLAGS_EN
    output logic [4:0]  fflags,
`endif
    output logic [31:0] float_write_data
);

    localparam int unsigned STATE_W = $clog2(LATENCY_STAGES + 1);
    localparam int unsigned MANT_W  = 27;  // hidden + 23 frac + guard/round/sticky
    localparam int unsigned EXP_W   = 10;  // signed headroom for under/overflow

    typedef enum logic [STATE_W-1:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_e;

    state_e state_q, state_d;
    logic   wb_en_d;
    logic   accept;

    logic [31:0] op_a_q, op_b_q;
    logic        op_sub_q;
    logic [5:0]  rd_q;

    logic              sign_l_q, sign_s_q, spec_q;
    logic [7:0]        exp_l_q;
    logic [MANT_W-1:0] mant_l_q, mant_s_q;
    logic [31:0]       spec_res_q;

    logic [MANT_W:0]   sum_q;
    logic              sign_r_q;

    logic [MANT_W-1:0]        mant_n_q;
    logic signed [EXP_W-1:0]  exp_n_q;

    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign accept   = (state_q == IDLE) && in_valid && !kill;

    // Control: fixed walk through the datapath stages, kill returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        wb_en_d = 1'b0;
        unique case (state_q)
            IDLE:    if (accept) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND: begin
                state_d = IDLE;
                wb_en_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (kill && (state_q != IDLE)) begin
            state_d = IDLE;
            wb_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_sub_q <= 1'b0;
            rd_q     <= '0;
        end else if (accept) begin
            op_a_q   <= in_rs1_data;
            op_b_q   <= in_rs2_data;
            op_sub_q <= in_op;
            rd_q     <= in_rd_addr;
        end
    end

    // ALIGN: unpack, classify specials, order by magnitude, shift the smaller mantissa
    logic              sign_a, sign_b, nan_a, nan_b, inf_a, inf_b, inf_clash;
    logic [30:0]       mag_a, mag_b, mag_l, mag_s;
    logic [7:0]        exp_diff;
    logic [MANT_W-1:0] mant_s_full, lost_mask, mant_l_c, mant_s_c;
    logic              sign_l_c, sign_s_c, spec_c;
    logic [31:0]       spec_res_c;

    always_comb begin
        sign_a    = op_a_q[31];
        sign_b    = op_b_q[31] ^ op_sub_q;
        nan_a     = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] != 23'd0);
        nan_b     = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] != 23'd0);
        inf_a     = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] == 23'd0);
        inf_b     = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] == 23'd0);
        inf_clash = inf_a && inf_b && (sign_a != sign_b);
        mag_a     = (op_a_q[30:23] == 8'd0) ? 31'd0 : op_a_q[30:0];
        mag_b     = (op_b_q[30:23] == 8'd0) ? 31'd0 : op_b_q[30:0];
        sign_l_c  = sign_a;
        sign_s_c  = sign_b;
        mag_l     = mag_a;
        mag_s     = mag_b;
        if (mag_b > mag_a) begin
            sign_l_c = sign_b;
            sign_s_c = sign_a;
            mag_l    = mag_b;
            mag_s    = mag_a;
        end
        mant_l_c    = (mag_l == 31'd0) ? '0 : {1'b1, mag_l[22:0], 3'b000};
        mant_s_full = (mag_s == 31'd0) ? '0 : {1'b1, mag_s[22:0], 3'b000};
        exp_diff    = mag_l[30:23] - mag_s[30:23];
        lost_mask   = ~({MANT_W{1'b1}} << exp_diff);
        if (exp_diff >= 8'd26) begin
            mant_s_c = {{(MANT_W-1){1'b0}}, |mant_s_full};
        end else begin
            mant_s_c    = mant_s_full >> exp_diff;
            mant_s_c[0] = mant_s_c[0] | (|(mant_s_full & lost_mask));
        end
        spec_c = nan_a | nan_b | inf_a | inf_b;
        if (nan_a || nan_b || inf_clash) spec_res_c = CANON_NAN;
        else                             spec_res_c = {(inf_a ? sign_a : sign_b), 8'hFF, 23'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            exp_l_q    <= '0;
            mant_l_q   <= '0;
            mant_s_q   <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
        end else if (state_q == ALIGN) begin
            sign_l_q   <= sign_l_c;
            sign_s_q   <= sign_s_c;
            exp_l_q    <= mag_l[30:23];
            mant_l_q   <= mant_l_c;
            mant_s_q   <= mant_s_c;
            spec_q     <= spec_c;
            spec_res_q <= spec_res_c;
        end
    end

    // ADD: magnitude add/subtract; an exact zero is negative only if both inputs were
    logic [MANT_W:0] sum_c;
    logic            sign_r_c;

    always_comb begin
        if (sign_l_q == sign_s_q) sum_c = {1'b0, mant_l_q} + {1'b0, mant_s_q};
        else                      sum_c = {1'b0, mant_l_q} - {1'b0, mant_s_q};
        sign_r_c = (sum_c == '0) ? (sign_l_q & sign_s_q) : sign_l_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            sign_r_q <= 1'b0;
        end else if (state_q == ADD) begin
            sum_q    <= sum_c;
            sign_r_q <= sign_r_c;
        end
    end

    // NORM: carry-out right shift or leading-zero left shift
    logic [4:0]              lzc;
    logic [MANT_W-1:0]       mant_n_c;
    logic signed [EXP_W-1:0] exp_n_c;

    always_comb begin
        lzc      = '0;
        mant_n_c = '0;
        exp_n_c  = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (sum_q[i]) lzc = 5'(MANT_W - 1 - i);
        end
        if (sum_q[MANT_W]) begin
            mant_n_c = {sum_q[MANT_W:2], sum_q[1] | sum_q[0]};
            exp_n_c  = EXP_W'(exp_l_q) + EXP_W'(1);
        end else begin
            mant_n_c = sum_q[MANT_W-1:0] << lzc;
            exp_n_c  = EXP_W'(exp_l_q) - EXP_W'(lzc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_n_q <= '0;
            exp_n_q  <= '0;
        end else if (state_q == NORM) begin
            mant_n_q <= mant_n_c;
            exp_n_q  <= exp_n_c;
        end
    end

    // ROUND: nearest-even, renormalise on mantissa carry, clamp to inf / flush to zero
    logic                    round_up;
    logic [24:0]             rounded;
    logic [22:0]             frac_r;
    logic signed [EXP_W-1:0] exp_r;
    logic [31:0]             result_c;

    always_comb begin
        round_up = mant_n_q[2] & (mant_n_q[1] | mant_n_q[0] | mant_n_q[3]);
        rounded  = {1'b0, mant_n_q[MANT_W-1:3]} + 25'(round_up);
        frac_r   = rounded[22:0];
        exp_r    = exp_n_q;
        if (rounded[24]) begin
            frac_r = rounded[23:1];
            exp_r  = exp_n_q + 10'sd1;
        end
        if (spec_q)                  result_c = spec_res_q;
        else if (mant_n_q == '0)     result_c = {sign_r_q, 31'd0};
        else if (exp_r >= 10'sd255)  result_c = {sign_r_q, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)    result_c = {sign_r_q, 31'd0};
        else                         result_c = {sign_r_q, exp_r[7:0], frac_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            float_wb_en      <= 1'b0;
            float_wb_addr    <= '0;
            float_write_data <= '0;
        end else begin
            float_wb_en <= wb_en_d;
            if (wb_en_d) begin
                float_wb_addr    <= rd_q;
                float_write_data <= result_c;
            end
        end
    end

`ifdef FPU_FLAGS_EN
    // Exception flags, held only for the write-back cycle
    logic       nv_c, nv_q;
    logic [4:0] flags_c;

    always_comb begin
        nv_c = inf_clash | (nan_a & ~op_a_q[22]) | (nan_b & ~op_b_q[22]);
    end

    always_comb begin
        flags_c = 5'd0;
        if (spec_q) begin
            flags_c[4] = nv_q;
        end else if (mant_n_q != '0) begin
            if (exp_r >= 10'sd255)   flags_c = 5'b00101;
            else if (exp_r <= 10'sd0) flags_c = 5'b00011;
            else                     flags_c[0] = |mant_n_q[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nv_q   <= 1'b0;
            fflags <= '0;
        end else begin
            if (state_q == ALIGN) nv_q <= nv_c;
            fflags <= wb_en_d ? flags_c : 5'd0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_addsub_unit.sv
`timescale 1ns/1ps
// tb_fp_addsub_unit: directed scoreboard bench for fp_addsub_unit (timing, rounding, specials, kill, reset).
module tb_fp_addsub_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_op, kill, busy;
    logic [5:0]  in_rd_addr, float_wb_addr;
    logic [31:0] in_rs1_data, in_rs2_data, float_write_data;
    logic        float_wb_en;
`ifdef FPU_FLAGS_EN
    logic [4:0]  fflags;
`endif

    fp_addsub_unit dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_rd_addr       (in_rd_addr),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .kill             (kill),
        .busy             (busy),
        .float_wb_en      (float_wb_en),
        .float_wb_addr    (float_wb_addr),
`ifdef FPU_FLAGS_EN
        .fflags           (fflags),
`endif
        .float_write_data (float_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd_addr  = rd;
    endtask

    task automatic expect_wb(input string tag, input logic [5:0] rd, input logic [31:0] d, input logic [4:0] f);
        exp_t e;
        e.tag   = tag;
        e.addr  = rd;
        e.data  = d;
        e.flags = f;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] rd, input logic [31:0] d, input logic [4:0] f);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        drive(op, a, b, rd);
        expect_wb(tag, rd, d, f);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every write-back pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (float_wb_en) begin
                check("wb_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.tag, "_addr"}, 64'(float_wb_addr), 64'(mon_e.addr));
                    check({mon_e.tag, "_data"}, 64'(float_write_data), 64'(mon_e.data));
`ifdef FPU_FLAGS_EN
                    check({mon_e.tag, "_flags"}, 64'(fflags), 64'(mon_e.flags));
`endif
                end
            end
`ifdef FPU_FLAGS_EN
            else begin
                check("fflags_idle", 64'(fflags), 64'd0);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  wb6, rdy6, busy6;
        logic [6:0]  wb7, rdy7;
        logic [10:0] wb11, rdy11;
        logic        any_wb;

        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; kill = 1'b0;
        in_rd_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_wb_en", 64'(float_wb_en), 64'd0);
        check("rst_addr",  64'(float_wb_addr), 64'd0);
        check("rst_data",  64'(float_write_data), 64'd0);
        rst = 1'b0;

        // First op with cycle-exact pulse and ready timing
        @(negedge clk);
        drive(1'b0, 32'h3F800000, 32'h40000000, 6'h23);
        expect_wb("add_1_2", 6'h23, 32'h40400000, 5'b00000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wb6[k] = float_wb_en; rdy6[k] = in_ready; busy6[k] = busy;
        end
        check("first_wb_timing",    64'(wb6),   64'(6'b010000));
        check("first_ready_timing", 64'(rdy6),  64'(6'b110000));
        check("first_busy_timing",  64'(busy6), 64'(6'b001111));

        run_op("sub_equal",     1'b1, 32'h3F800000, 32'h3F800000, 6'h01, 32'h00000000, 5'b00000);
        run_op("negz_add",      1'b0, 32'h80000000, 32'h80000000, 6'h02, 32'h80000000, 5'b00000);
        run_op("negz_sub_posz", 1'b1, 32'h80000000, 32'h00000000, 6'h03, 32'h80000000, 5'b00000);
        run_op("tie_even",      1'b0, 32'h3F800000, 32'h33800000, 6'h04, 32'h3F800000, 5'b00001);
        run_op("above_tie",     1'b0, 32'h3F800000, 32'h33800001, 6'h05, 32'h3F800001, 5'b00001);
        run_op("round_carry",   1'b0, 32'h3F7FFFFF, 32'h33000000, 6'h06, 32'h3F800000, 5'b00001);
        run_op("carry_norm",    1'b0, 32'h3FC00000, 32'h40200000, 6'h07, 32'h40800000, 5'b00000);
        run_op("sub_pos",       1'b1, 32'h40000000, 32'h3F800000, 6'h08, 32'h3F800000, 5'b00000);
        run_op("sub_neg",       1'b1, 32'h3F800000, 32'h40000000, 6'h09, 32'hBF800000, 5'b00000);
        run_op("inf_clash",     1'b0, 32'h7F800000, 32'hFF800000, 6'h0A, 32'h7FC00000, 5'b10000);
        run_op("overflow",      1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 6'h0B, 32'h7F800000, 5'b00101);
        run_op("qnan_in",       1'b0, 32'h7FC00001, 32'h3F800000, 6'h0C, 32'h7FC00000, 5'b00000);
        run_op("snan_in",       1'b0, 32'h7F800001, 32'h3F800000, 6'h0D, 32'h7FC00000, 5'b10000);
        run_op("fin_minus_inf", 1'b1, 32'h3F800000, 32'h7F800000, 6'h0E, 32'hFF800000, 5'b00000);
        run_op("subnormal_ftz", 1'b0, 32'h00000001, 32'h3F800000, 6'h0F, 32'h3F800000, 5'b00000);
        run_op("underflow_ftz", 1'b1, 32'h00800001, 32'h00800000, 6'h10, 32'h00000000, 5'b00011);
        run_op("rd_x0",         1'b0, 32'h3F800000, 32'h3F800000, 6'h00, 32'h40000000, 5'b00000);

        // kill in NORM at E3, new op at E4 pulses at E8..E9
        @(negedge clk);
        drive(1'b0, 32'h40400000, 32'h40400000, 6'h2A);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            wb7[k] = float_wb_en; rdy7[k] = in_ready;
            if (k == 0) begin
                drive(1'b0, 32'h40000000, 32'h40000000, 6'h2B);
                expect_wb("after_kill", 6'h2B, 32'h40800000, 5'b00000);
            end
            if (k == 1) in_valid = 1'b0;
        end
        check("kill_wb_timing",    64'(wb7),  64'(7'b0100000));
        check("kill_ready_timing", 64'(rdy7), 64'(7'b1100001));

        // kill in ROUND suppresses the pulse
        @(negedge clk);
        drive(1'b0, 32'h3F800000, 32'h3F800000, 6'h2C);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_round_wb",    64'(float_wb_en), 64'd0);
        check("kill_round_ready", 64'(in_ready), 64'd1);

        // kill wins over accept while idle
        drive(1'b0, 32'h3F800000, 32'h3F800000, 6'h2D);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("kill_blocks_accept", 64'(busy), 64'd0);

        // back-to-back with in_valid held: second accepted at E5
        @(negedge clk);
        drive(1'b0, 32'h3F800000, 32'h40000000, 6'h31);
        expect_wb("b2b_first", 6'h31, 32'h40400000, 5'b00000);
        @(posedge clk);
        #1 drive(1'b0, 32'h40000000, 32'h40000000, 6'h32);
        expect_wb("b2b_second", 6'h32, 32'h40800000, 5'b00000);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            wb11[k] = float_wb_en; rdy11[k] = in_ready;
            if (k == 5) in_valid = 1'b0;
        end
        check("b2b_wb_timing",    64'(wb11),  64'(11'b01000010000));
        check("b2b_ready_timing", 64'(rdy11), 64'(11'b11000010000));
        check("b2b_drain",        64'(exp_q.size()), 64'd0);

        // async reset mid-operation
        @(negedge clk);
        drive(1'b1, 32'h40400000, 32'h3F800000, 6'h33);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_wb_en", 64'(float_wb_en), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_busy",  64'(busy), 64'd0);
        check("midrst_addr",  64'(float_wb_addr), 64'd0);
        check("midrst_data",  64'(float_write_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        any_wb = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_wb = any_wb | float_wb_en;
        end
        check("midrst_no_pulse", 64'(any_wb), 64'd0);

        run_op("post_reset", 1'b0, 32'h3F800000, 32'h40000000, 6'h3F, 32'h40400000, 5'b00000);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
